// File: rtl/mlp_engine_pkg.sv
// Shared types and layer-geometry helpers for mlp_engine.
// MLP_ARGMAX_EN (when defined) adds the ARGMAX state to the state enum.
package mlp_engine_pkg;

  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned SAT_W     = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef MLP_ARGMAX_EN
    S_ARGMAX,
`endif
    S_HOLD
  } state_t;

  function automatic int unsigned layer_in_dim(input int unsigned l, input int unsigned in_dim,
                                               input int unsigned hid_dim);
    return (l == 0) ? in_dim : hid_dim;
  endfunction

  function automatic int unsigned layer_out_dim(input int unsigned l, input int unsigned num_hidden,
                                                input int unsigned hid_dim, input int unsigned out_dim);
    return (l == num_hidden) ? out_dim : hid_dim;
  endfunction

  // First weight-word address of layer l: every earlier layer holds G*(N_in+1) words.
  function automatic int unsigned layer_base(input int unsigned l, input int unsigned in_dim,
                                             input int unsigned hid_dim, input int unsigned out_dim,
                                             input int unsigned num_hidden, input int unsigned p);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < l; i++)
      b += ((layer_out_dim(i, num_hidden, hid_dim, out_dim) + p - 1) / p)
           * (layer_in_dim(i, in_dim, hid_dim) + 1);
    return b;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [SAT_W-1:0] v);
    if (v > 64'sd32767)
      return 16'sh7fff;
    else if (v < -64'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/mlp_engine_if.sv
// Handshake and weight-memory bus of mlp_engine; slave = engine side, master = environment.
interface mlp_engine_if #(
    parameter int unsigned IN_DIM  = 33,
    parameter int unsigned OUT_DIM = 10,
    parameter int unsigned P       = 16
);
    localparam int unsigned IW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [IN_DIM*16-1:0]    in_data;
    logic                    w_rd;
    logic [31:0]             w_addr;
    logic [P*16-1:0]         w_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_DIM*16-1:0]   out_data;
    logic [IW-1:0]           out_idx;
    logic                    busy;

    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_rd, w_addr, out_valid, out_data, out_idx, busy
    );

    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_rd, w_addr, out_valid, out_data, out_idx, busy
    );
endinterface

// File: rtl/mlp_mac_lane.sv
// One MAC lane: clearable accumulator plus combinational bias/shift/saturate/ReLU finalise.
module mlp_mac_lane
    import mlp_engine_pkg::*;
#(
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned FRAC_BITS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_acc,
    input  logic signed [15:0] i_act,
    input  logic signed [15:0] i_w,
    input  logic               i_relu,
    output logic signed [15:0] o_res
);
    logic signed [ACC_W-1:0] r_acc;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [SAT_W-1:0] w_shifted;
    logic signed [15:0]      w_sat;

    // During finalise i_w carries the bias word, aligned to the accumulator's Q-point.
    always_comb begin
        w_prod    = i_act * i_w;
        w_sum     = r_acc + (ACC_W'(i_w) <<< FRAC_BITS);
        w_shifted = SAT_W'(w_sum >>> FRAC_BITS);
        w_sat     = sat16(w_shifted);
        o_res     = (i_relu && w_sat[15]) ? '0 : w_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_acc)
            r_acc <= r_acc + ACC_W'(w_prod);
    end
endmodule

// File: rtl/mlp_engine.sv
// Time-multiplexed MLP engine: one P-lane MAC datapath sequenced over NUM_HIDDEN+1 layers.
// Define MLP_ARGMAX_EN to add the sequential argmax scan (out_idx) before HOLD.
module mlp_engine
    import mlp_engine_pkg::*;
#(
    parameter int unsigned IN_DIM     = 33,
    parameter int unsigned HID_DIM    = 128,
    parameter int unsigned OUT_DIM    = 10,
    parameter int unsigned NUM_HIDDEN = 2,
    parameter int unsigned P          = 16,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned ACC_W      = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mlp_engine_if.slave bus
);
    localparam int unsigned MAXD  = (IN_DIM > HID_DIM) ? IN_DIM : HID_DIM;
    localparam int unsigned KW    = $clog2(MAXD + 2);
    localparam int unsigned G_HID = (HID_DIM + P - 1) / P;
    localparam int unsigned G_OUT = (OUT_DIM + P - 1) / P;
    localparam int unsigned GMAX  = (G_HID > G_OUT) ? G_HID : G_OUT;
    localparam int unsigned GW    = (GMAX > 1) ? $clog2(GMAX) : 1;
    localparam int unsigned IW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    state_t                  r_state, w_state_nx;
    logic [2:0]              r_layer;
    logic [GW-1:0]           r_grp;
    logic [KW-1:0]           r_k;
    logic [31:0]             r_addr;
    logic signed [15:0]      r_buf_a [MAXD];
    logic signed [15:0]      r_buf_b [MAXD];
    logic [OUT_DIM-1:0][15:0] r_out_data;

    logic [KW-1:0]           w_nin;
    logic                    w_last_layer, w_last_grp;
    logic                    w_issue, w_clr, w_acc, w_fin;
    logic signed [15:0]      w_act;
    logic signed [15:0]      w_res [P];
    logic [31:0]             w_base_nx;

`ifdef MLP_ARGMAX_EN
    logic [IW-1:0]           r_scan, r_idx;
    logic signed [15:0]      r_best, w_cur;
`endif

    // Group phase r_k: 0..N_in issue reads, 1..N_in accumulate, N_in+1 sees the bias word.
    always_comb begin
        w_last_layer = (r_layer == 3'(NUM_HIDDEN));
        w_nin        = KW'(layer_in_dim(32'(r_layer), IN_DIM, HID_DIM));
        w_last_grp   = (r_grp == (w_last_layer ? GW'(G_OUT - 1) : GW'(G_HID - 1)));
        w_issue      = (r_state == S_RUN) && (r_k <= w_nin);
        w_clr        = (r_state == S_RUN) && (r_k == '0);
        w_acc        = (r_state == S_RUN) && (r_k != '0) && (r_k <= w_nin);
        w_fin        = (r_state == S_RUN) && (r_k == w_nin + KW'(1));
        w_act        = '0;
        for (int unsigned i = 0; i < MAXD; i++)
            if (r_k == KW'(i + 1)) w_act = r_layer[0] ? r_buf_b[i] : r_buf_a[i];
        w_base_nx = '0;
        for (int unsigned l = 0; l < NUM_HIDDEN; l++)
            if (r_layer == 3'(l))
                w_base_nx = 32'(layer_base(l + 1, IN_DIM, HID_DIM, OUT_DIM, NUM_HIDDEN, P));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx    = r_state;
        bus.in_ready  = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
        bus.out_valid = (r_state == S_HOLD);
        bus.w_rd      = w_issue;
        bus.w_addr    = r_addr;
        unique case (r_state)
            S_IDLE: if (bus.in_valid) w_state_nx = S_RUN;
            S_RUN: begin
                if (w_fin && w_last_grp && w_last_layer) begin
`ifdef MLP_ARGMAX_EN
                    w_state_nx = S_ARGMAX;
`else
                    w_state_nx = S_HOLD;
`endif
                end
            end
`ifdef MLP_ARGMAX_EN
            S_ARGMAX: if (r_scan == IW'(OUT_DIM - 1)) w_state_nx = S_HOLD;
`endif
            S_HOLD: if (bus.out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer <= '0;
            r_grp   <= '0;
            r_k     <= '0;
            r_addr  <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.in_valid) begin
                r_layer <= '0;
                r_grp   <= '0;
                r_k     <= '0;
                r_addr  <= '0;
            end
        end else if (r_state == S_RUN) begin
            if (w_fin) begin
                r_k <= '0;
                if (w_last_grp) begin
                    r_grp   <= '0;
                    r_layer <= r_layer + 3'd1;
                    r_addr  <= w_base_nx;
                end else begin
                    r_grp <= r_grp + GW'(1);
                end
            end else begin
                r_k <= r_k + KW'(1);
                if (w_issue) r_addr <= r_addr + 32'd1;
            end
        end
    end

    // Neuron i only ever lands in lane i%P of group i/P, so out-of-range lanes never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_out_data <= '0;
        else if (w_fin && w_last_layer)
            for (int unsigned i = 0; i < OUT_DIM; i++)
                if (r_grp == GW'(i / P)) r_out_data[i] <= w_res[i % P];
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.in_valid) begin
            for (int unsigned i = 0; i < IN_DIM; i++)
                r_buf_a[i] <= bus.in_data[16*i +: 16];
        end else if (w_fin && !w_last_layer) begin
            for (int unsigned i = 0; i < HID_DIM; i++)
                if (r_grp == GW'(i / P)) begin
                    if (r_layer[0]) r_buf_a[i] <= w_res[i % P];
                    else            r_buf_b[i] <= w_res[i % P];
                end
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_lane
        mlp_mac_lane #(
            .ACC_W     (ACC_W),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (w_clr),
            .i_acc  (w_acc),
            .i_act  (w_act),
            .i_w    (bus.w_data[16*j +: 16]),
            .i_relu (!w_last_layer),
            .o_res  (w_res[j])
        );
    end

    assign bus.out_data = r_out_data;

`ifdef MLP_ARGMAX_EN
    always_comb begin
        w_cur = '0;
        for (int unsigned i = 0; i < OUT_DIM; i++)
            if (r_scan == IW'(i)) w_cur = r_out_data[i];
    end

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_best <= '0;
            r_idx  <= '0;
        end else if (r_state == S_ARGMAX) begin
            if (r_scan == '0 || w_cur > r_best) begin
                r_best <= w_cur;
                r_idx  <= r_scan;
            end
            r_scan <= (r_scan == IW'(OUT_DIM - 1)) ? '0 : r_scan + IW'(1);
        end
    end

    assign bus.out_idx = r_idx;
`else
    assign bus.out_idx = '0;
`endif
endmodule
